// File: rtl/intr_arbiter.sv
// Four-source interrupt arbiter for a small MCU: synchronizes and edge-detects IRQ lines,
// latches them as pending, and hands one granted source at a time to the MCU via INTR/VEC/ACK.
module intr_arbiter #(
  parameter logic [7:0] BASE_PORT = 8'hE0,
  parameter bit         RR_EN     = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] IRQ,
  input  logic       IO_STRB,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  output logic       INTR,
  output logic [7:0] IN_DATA,
  output logic       IN_VALID
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  localparam logic [1:0] OFF_MASK = 2'd0;
  localparam logic [1:0] OFF_PEND = 2'd1;
  localparam logic [1:0] OFF_VEC  = 2'd2;
  localparam logic [1:0] OFF_ACK  = 2'd3;

  state_e     state_q, state_d;
  logic [3:0] sync1_q, sync2_q, sync2_dly_q;
  logic [3:0] mask_q, mask_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] gid_q, gid_d;
  logic [1:0] last_q, last_d;
  logic       busy_q, busy_d;
  logic       intr_q;

  logic [7:0] offset;
  logic       wr_mask, wr_pend, wr_ack;
  logic [3:0] rise, eligible, grant_clr, w1c;
  logic [1:0] pick, scan_idx;
  logic       pick_vld;
  logic       unused_out_hi;

  // Register decode: offset wraps in 8 bits so any BASE_PORT alignment works.
  assign offset   = PORT_ID - BASE_PORT;
  assign IN_VALID = (offset < 8'd4);
  assign wr_mask  = IO_STRB && IN_VALID && (offset[1:0] == OFF_MASK);
  assign wr_pend  = IO_STRB && IN_VALID && (offset[1:0] == OFF_PEND);
  assign wr_ack   = IO_STRB && IN_VALID && (offset[1:0] == OFF_ACK);
  assign unused_out_hi = ^OUT_PORT[7:4];

  assign rise     = sync2_q & ~sync2_dly_q;
  assign eligible = pend_q & mask_q;
  assign w1c      = wr_pend ? OUT_PORT[3:0] : 4'h0;

  // Source selection: round-robin scans upward from last+1, fixed priority from 0.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    pick     = 2'd0;
    pick_vld = 1'b0;
    scan_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = RR_EN ? (last_q + 2'(k + 1)) : 2'(k);
      if (!pick_vld && eligible[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    busy_d    = busy_q;
    last_d    = last_q;
    grant_clr = 4'h0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d   = ASSERT;
          gid_d     = pick;
          busy_d    = 1'b1;
          last_d    = pick;
          grant_clr = 4'b0001 << pick;
        end
      end
      ASSERT: begin
        // Mask changes are deliberately ignored here; only an ACK ends service.
        if (wr_ack) begin
          state_d = HOLDOFF;
          busy_d  = 1'b0;
        end
      end
      HOLDOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new edge always wins over a same-cycle W1C or grant clear.
  assign pend_d = (pend_q & ~w1c & ~grant_clr) | rise;
  assign mask_d = wr_mask ? OUT_PORT[3:0] : mask_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      sync1_q     <= 4'h0;
      sync2_q     <= 4'h0;
      sync2_dly_q <= 4'h0;
      mask_q      <= 4'h0;
      pend_q      <= 4'h0;
      gid_q       <= 2'd0;
      last_q      <= 2'd3;
      busy_q      <= 1'b0;
      state_q     <= IDLE;
      intr_q      <= 1'b0;
    end else begin
      sync1_q     <= IRQ;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      gid_q       <= gid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      state_q     <= state_d;
      intr_q      <= (state_d == ASSERT);
    end
  end

  assign INTR = intr_q;

  always_comb begin
    IN_DATA = 8'h00;
    if (IN_VALID) begin
      unique case (offset[1:0])
        OFF_MASK: IN_DATA = {4'h0, mask_q};
        OFF_PEND: IN_DATA = {4'h0, pend_q};
        OFF_VEC:  IN_DATA = {4'h0, busy_q, 1'b0, gid_q};
        OFF_ACK:  IN_DATA = 8'h00;
        default:  IN_DATA = 8'h00;
      endcase
    end
  end

endmodule

// File: doc/intr_arbiter.md
INTR_ARBITER -- requirements
Module: intr_arbiter

Interface
REQ-001 SHALL have parameter BASE_PORT, default 8'hE0, the first of four consecutive port IDs owned by the block.
REQ-002 SHALL have parameter RR_EN, default 1; 1 selects round-robin grant, 0 selects fixed priority with IRQ[0] highest.
REQ-003 SHALL have port CLK  in  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port IRQ  in  4  peripheral interrupt requests; asynchronous to CLK; the rising edge is the event.
REQ-006 SHALL have port IO_STRB  in  1  MCU output strobe; a one-cycle write qualifier.
REQ-007 SHALL have port PORT_ID  in  8  MCU port address.
REQ-008 SHALL have port OUT_PORT  in  8  MCU write data.
REQ-009 SHALL have port INTR  out  1  registered interrupt request to the MCU INTR input.
REQ-010 SHALL have port IN_DATA  out  8  combinational read data, driven to the MCU IN_PORT mux.
REQ-011 SHALL have port IN_VALID  out  1  combinational; 1 when PORT_ID is in BASE_PORT..BASE_PORT+3.

Function
REQ-012 SHALL provide the register map below; a write occurs only on a cycle with IO_STRB=1 and a matching PORT_ID.
- +0 MASK: read/write; bits [3:0] enable the corresponding sources.
- +1 PEND: read; write-1-to-clear on bits [3:0].
- +2 VEC: read only; returns {4'b0, busy, 1'b0, gid[1:0]}.
- +3 ACK: write of any value acknowledges; reads return 8'h00.
REQ-013 SHALL drive IN_DATA to 8'h00 when IN_VALID=0; unused read bits SHALL read as 0.
REQ-014 SHALL synchronize each IRQ bit through two flops, then detect a rising edge as sync2 & ~sync2_d.
REQ-015 SHALL set PEND[i] on the edge when the detected rising edge is registered: IRQ high before edge 1 gives PEND[i]=1 after edge 3.
REQ-016 SHALL use the FSM states IDLE, ASSERT and HOLDOFF.
- IDLE: INTR=0.
- ASSERT: INTR=1.
- HOLDOFF: INTR=0 for exactly one cycle.
REQ-017 SHALL transition IDLE->ASSERT when (PEND & MASK) != 0; on that edge it SHALL latch gid, set busy=1, clear PEND[gid] and record last=gid. With REQ-015, INTR=1 after edge 4.
REQ-018 SHALL choose gid, when RR_EN=1, as the first eligible source scanning upward from last+1 modulo 4 (wrap 3->0).
REQ-019 SHALL choose gid, when RR_EN=0, as the lowest-index eligible source.
REQ-020 SHALL transition ASSERT->HOLDOFF on an ACK write and clear busy on that edge; an ACK write in IDLE or HOLDOFF SHALL have no effect.
REQ-021 SHALL transition HOLDOFF->IDLE unconditionally.
REQ-022 SHALL hold INTR and gid stable in ASSERT even if MASK[gid] is cleared; a MASK change affects only future grants.
REQ-023 SHALL retain pending bits of unmasked-off sources; setting MASK later SHALL make them eligible.
REQ-024 SHALL resolve a new edge on source i in the same cycle as a W1C or grant-clear of PEND[i] as set-wins (PEND[i]=1).
REQ-025 SHALL treat a second edge on an already-pending source as lost; no counting.
REQ-026 SHALL perform any PEND W1C concurrently with a grant decision without corrupting the other bits.

Reset
REQ-027 SHALL, while RESET_N=0 (asynchronous):
- clear MASK, PEND, gid, busy and all synchronizer flops to 0;
- set last to 3;
- place the FSM in IDLE;
- drive INTR=0.
REQ-028 SHALL abandon an in-progress ASSERT when RESET_N is asserted mid-operation: INTR falls without waiting for a clock edge, and no ACK is required afterwards.
REQ-029 SHALL resume normal operation on the first rising CLK edge after RESET_N deasserts; the first round-robin grant SHALL select source 0 when it is eligible.

Verification
REQ-030 SHALL cover this case: MASK<=8'h0F, IRQ[2] rises -> PEND=8'h04 after edge 3, INTR=1 after edge 4, VEC=8'h0A, PEND=8'h00; ACK write -> INTR=0 for 2 cycles minimum, VEC=8'h02.
REQ-031 SHALL cover this case: RR_EN=1, MASK=8'h0F, IRQ[0], IRQ[1] and IRQ[3] rise together -> grants with ACK between are 0, 1, 3; then IRQ[0] and IRQ[3] again -> grant 0 (wrap from last=3).
REQ-032 SHALL cover this case: MASK=8'h00, IRQ[1] rises -> PEND=8'h02, INTR stays 0; MASK<=8'h02 -> INTR=1 two edges later, gid=1.
REQ-033 SHALL cover this case: write PEND<=8'h01 in the same cycle IRQ[0]'s edge registers -> PEND[0]=1.
REQ-034 SHALL cover this case: MASK<=8'h01 while in ASSERT with gid=0 -> INTR remains 1 until ACK; read of PORT_ID=BASE_PORT+3 -> IN_DATA=8'h00, IN_VALID=1; PORT_ID=BASE_PORT+4 -> IN_VALID=0, IN_DATA=8'h00.
REQ-035 SHALL cover this case: RESET_N low during ASSERT -> INTR=0 immediately, MASK=8'h00; after release, a new IRQ[3] edge with MASK=8'h08 -> normal grant, gid=3.
